fir_mac_sequencer: RTL

- Time-multiplexed FIR controller: one shared 16x20 signed multiplier-accumulator is sequenced over all taps for each accepted input sample.
- Replaces a fully parallel 32-tap datapath; trades throughput (one sample per TAPS+3 cycles) for area.
- Sits between the sample source (valid/ready) and the output consumer (single-cycle valid pulse).
- Owns a circular sample buffer and drives the read address of an external synchronous coefficient ROM.

---
 rtl/fir_mac_sequencer_if.sv | 34 +++
 rtl/fir_mac_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if
// Groups the sample handshake, coefficient ROM bus and filtered-output
// signals of fir_mac_sequencer.
//   data_valid / data     : sample strobe and signed 16-bit sample
//   ready                 : sequencer can take a sample this cycle
//   coef_addr / coef_data : synchronous ROM address out, Q4.16 coefficient in
//   fir_valid / fir_d     : one-cycle output pulse and signed 16-bit result
//   done / overflow       : sticky status flags
// Modports: master = sample source / ROM / consumer side, slave = sequencer.
interface fir_mac_sequencer_if #(
    parameter int TAPS = 32
);
    localparam int AW = $clog2(TAPS);

    logic                 data_valid;
    logic signed [15:0]   data;
    logic                 ready;
    logic [AW-1:0]        coef_addr;
    logic signed [19:0]   coef_data;
    logic                 fir_valid;
    logic signed [15:0]   fir_d;
    logic                 done;
    logic                 overflow;

    modport master (
        output data_valid, data, coef_data,
        input  ready, coef_addr, fir_valid, fir_d, done, overflow
    );

    modport slave (
        input  data_valid, data, coef_data,
        output ready, coef_addr, fir_valid, fir_d, done, overflow
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Time-multiplexed FIR controller. Each accepted sample is written into a
// circular buffer, then one shared 16x20 signed MAC walks all TAPS taps
// (newest sample against coefficient 0). One sample is processed every
// TAPS+3 cycles; the result appears TAPS+2 cycles after the accept.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : fir_mac_sequencer_if.slave (handshake, coefficient ROM, output)
// Parameters: TAPS (power of two, 4..64), NUM_OUT outputs before done,
// ACC_W accumulator width (>= 36).
// Build option: define FIR_SAT_EN to clamp the rounded result to the
// 16-bit signed range instead of letting it wrap.
module fir_mac_sequencer #(
    parameter int TAPS    = 32,
    parameter int NUM_OUT = 1024,
    parameter int ACC_W   = 36
) (
    input  logic               clk,
    input  logic               rst,
    fir_mac_sequencer_if.slave bus
);
    localparam int AW  = $clog2(TAPS);
    localparam int SCW = $clog2(TAPS + 1);
    localparam int OCW = $clog2(NUM_OUT + 1);

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          coef_addr_q, coef_addr_d;
    logic signed [15:0]     sample_r_q, sample_r_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [SCW-1:0]         sample_cnt_q, sample_cnt_d;
    logic [OCW-1:0]         out_cnt_q, out_cnt_d;
    logic                   fir_valid_q, fir_valid_d;
    logic signed [15:0]     fir_d_q, fir_d_d;
    logic                   done_q, done_d;
    logic                   overflow_q, overflow_d;

    logic signed [15:0]     sample_mem [TAPS];
    logic                   mem_we;
    logic                   ready;
    logic                   accept;
    logic signed [35:0]     product;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [15:0]     rounded;

    // Products are sign-extended into the full accumulator; no truncation.
    always_comb begin
        product = sample_r_q * bus.coef_data;
        acc_sum = acc_q + ACC_W'(product);
    end

`ifdef FIR_SAT_EN
    logic signed [16:0] rounded_wide;

    // Round half up at 17 bits, then clamp into the 16-bit signed range.
    always_comb begin
        rounded_wide = {acc_sum[31], acc_sum[31:16]} + {16'd0, acc_sum[15]};
        if (rounded_wide > 17'sd32767) begin
            rounded = 16'sh7FFF;
        end else if (rounded_wide < -17'sd32768) begin
            rounded = -16'sd32768;
        end else begin
            rounded = rounded_wide[15:0];
        end
    end
`else
    // Round half up; the result simply wraps on overflow.
    always_comb begin
        rounded = acc_sum[31:16] + {15'd0, acc_sum[15]};
    end
`endif

    // Next-state logic. The ROM and the sample register each add one cycle,
    // so the product for tap k is accumulated when coef_addr already shows
    // k+1; the last product lands in DRAIN, whose sum feeds the output.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        coef_addr_d  = coef_addr_q;
        sample_r_d   = sample_r_q;
        acc_d        = acc_q;
        sample_cnt_d = sample_cnt_q;
        out_cnt_d    = out_cnt_q;
        fir_valid_d  = 1'b0;
        fir_d_d      = fir_d_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        mem_we       = 1'b0;
        ready        = (state_q == IDLE) && !done_q;
        accept       = bus.data_valid && ready;

        if (bus.data_valid && !ready) begin
            overflow_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_we      = 1'b1;
                    wr_ptr_d    = wr_ptr_q + AW'(1);
                    rd_ptr_d    = wr_ptr_q;
                    acc_d       = '0;
                    coef_addr_d = '0;
                    if (sample_cnt_q != SCW'(TAPS)) begin
                        sample_cnt_d = sample_cnt_q + SCW'(1);
                    end
                    state_d = MAC;
                end
            end
            MAC: begin
                sample_r_d = sample_mem[rd_ptr_q];
                rd_ptr_d   = rd_ptr_q - AW'(1);
                if (coef_addr_q != '0) begin
                    acc_d = acc_sum;
                end
                if (coef_addr_q == AW'(TAPS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    coef_addr_d = coef_addr_q + AW'(1);
                end
            end
            DRAIN: begin
                acc_d = acc_sum;
                // Warm-up results are computed but never presented.
                if (sample_cnt_q == SCW'(TAPS)) begin
                    fir_valid_d = 1'b1;
                    fir_d_d     = rounded;
                    if (out_cnt_q != OCW'(NUM_OUT)) begin
                        out_cnt_d = out_cnt_q + OCW'(1);
                    end
                    if (out_cnt_q == OCW'(NUM_OUT - 1)) begin
                        done_d = 1'b1;
                    end
                end
                state_d = OUT;
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            coef_addr_q  <= '0;
            sample_r_q   <= '0;
            acc_q        <= '0;
            sample_cnt_q <= '0;
            out_cnt_q    <= '0;
            fir_valid_q  <= 1'b0;
            fir_d_q      <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            coef_addr_q  <= coef_addr_d;
            sample_r_q   <= sample_r_d;
            acc_q        <= acc_d;
            sample_cnt_q <= sample_cnt_d;
            out_cnt_q    <= out_cnt_d;
            fir_valid_q  <= fir_valid_d;
            fir_d_q      <= fir_d_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Sample storage is deliberately left unreset; warm-up suppression
    // hides stale contents until every slot has been rewritten.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            sample_mem[wr_ptr_q] <= bus.data;
        end
    end

    assign bus.ready     = ready;
    assign bus.coef_addr = coef_addr_q;
    assign bus.fir_valid = fir_valid_q;
    assign bus.fir_d     = fir_d_q;
    assign bus.done      = done_q;
    assign bus.overflow  = overflow_q;
endmodule
